// File: rtl/register_file.sv
// Architectural register file: 32 x WORD_SIZE registers, two registered read ports
// with same-cycle writeback bypass, and a pending-write scoreboard driving hazard.
module register_file #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] write_data,
  input  logic [4:0]           write_addr,
  input  logic                 write_enable,
  input  logic                 rd_en,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic [WORD_SIZE-1:0] rs1_data,
  output logic [WORD_SIZE-1:0] rs2_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 hazard,
  output logic [31:0]          busy_mask
);

  logic [WORD_SIZE-1:0] r_regs [NUM_REGS];
  logic [31:0]          r_busy;
  logic [WORD_SIZE-1:0] r_rs1Data;
  logic [WORD_SIZE-1:0] r_rs2Data;

  logic                 w_byp1;
  logic                 w_byp2;
  logic                 w_blk1;
  logic                 w_blk2;
  logic                 w_hazard;
  logic [WORD_SIZE-1:0] w_rd1Val;
  logic [WORD_SIZE-1:0] w_rd2Val;
  logic [31:0]          w_busyNext;

  // A writeback landing this cycle is forwarded so decode never sees the stale value.
  assign w_byp1 = write_enable && (write_addr == rs1_addr) && (rs1_addr != 5'd0);
  assign w_byp2 = write_enable && (write_addr == rs2_addr) && (rs2_addr != 5'd0);

  always_comb begin
    w_rd1Val = r_regs[rs1_addr];
    if (rs1_addr == 5'd0) begin
      w_rd1Val = '0;
    end else if (w_byp1) begin
      w_rd1Val = write_data;
    end
  end

  always_comb begin
    w_rd2Val = r_regs[rs2_addr];
    if (rs2_addr == 5'd0) begin
      w_rd2Val = '0;
    end else if (w_byp2) begin
      w_rd2Val = write_data;
    end
  end

  assign w_blk1   = r_busy[rs1_addr] && !w_byp1;
  assign w_blk2   = r_busy[rs2_addr] && !w_byp2;
  assign w_hazard = rd_en && (w_blk1 || w_blk2);

  // Set is applied after clear so a new producer keeps the register busy.
  always_comb begin
    w_busyNext = r_busy;
    if (write_enable) begin
      w_busyNext[write_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      w_busyNext[issue_rd] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (write_enable && (write_addr != 5'd0)) begin
      r_regs[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rs1Data <= '0;
      r_rs2Data <= '0;
    end else if (rd_en && !w_hazard) begin
      r_rs1Data <= w_rd1Val;
      r_rs2Data <= w_rd2Val;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign rs1_data  = r_rs1Data;
  assign rs2_data  = r_rs2Data;
  assign hazard    = w_hazard;
  assign busy_mask = r_busy;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against an array-based reference model.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] write_data = '0;
  logic [4:0]  write_addr = '0;
  logic        write_enable = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        hazard;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  logic [31:0] mRegs [32];
  logic [31:0] mBusy = '0;
  logic [31:0] mRs1 = '0;
  logic [31:0] mRs2 = '0;

  register_file #(.WORD_SIZE(32), .NUM_REGS(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .write_data  (write_data),
    .write_addr  (write_addr),
    .write_enable(write_enable),
    .rd_en       (rd_en),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .hazard      (hazard),
    .busy_mask   (busy_mask)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
  end

  function automatic logic [31:0] readVal(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (write_enable && write_addr == a) return write_data;
    return mRegs[a];
  endfunction

  function automatic logic expHazard();
    logic b1, b2;
    b1 = mBusy[rs1_addr] && !(write_enable && write_addr == rs1_addr && rs1_addr != 5'd0);
    b2 = mBusy[rs2_addr] && !(write_enable && write_addr == rs2_addr && rs2_addr != 5'd0);
    return rd_en && (b1 || b2);
  endfunction

  // Reference model: architectural state as a plain array plus a busy bitmap.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mBusy = '0;
      mRs1 = '0;
      mRs2 = '0;
    end else begin
      if (rd_en && !expHazard()) begin
        mRs1 = readVal(rs1_addr);
        mRs2 = readVal(rs2_addr);
      end
      if (write_enable && write_addr != 5'd0) mRegs[write_addr] = write_data;
      if (write_enable) mBusy[write_addr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) mBusy[issue_rd] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("model rs1_data", rs1_data, mRs1);
      checkOutput("model rs2_data", rs2_data, mRs2);
      checkOutput("model busy_mask", busy_mask, mBusy);
      checkOutput("model hazard", {31'b0, hazard}, {31'b0, expHazard()});
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                               input logic iv, input logic [4:0] ird);
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    rd_en        = rd;
    rs1_addr     = a1;
    rs2_addr     = a2;
    issue_valid  = iv;
    issue_rd     = ird;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  initial begin
    $display("[TB] starting register_file bench");
    #2 checkEn = 1'b1;
    #15 reset_n = 1'b1;
    tick();

    // Reset then read
    applyStimulus(0, 0, 0, 1, 5, 0, 0, 0);
    tick();
    checkOutput("reset rs1_data", rs1_data, 32'h0);
    checkOutput("reset rs2_data", rs2_data, 32'h0);
    checkOutput("reset busy_mask", busy_mask, 32'h0);
    checkOutput("reset hazard", {31'b0, hazard}, 32'h0);

    // Write then read, and x0 discard
    applyStimulus(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    checkOutput("write/read x7", rs1_data, 32'hDEADBEEF);
    applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    tick();
    checkOutput("read x0", rs1_data, 32'h0);

    // Same-cycle bypass on both ports
    applyStimulus(1, 3, 32'hA5A5A5A5, 1, 3, 3, 0, 0);
    tick();
    checkOutput("bypass rs1", rs1_data, 32'hA5A5A5A5);
    checkOutput("bypass rs2", rs2_data, 32'hA5A5A5A5);

    // Scoreboard stall and release
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    checkOutput("busy after issue 9", busy_mask, 32'h0000_0200);
    applyStimulus(0, 0, 0, 1, 0, 9, 0, 0);
    #1 checkOutput("stall hazard", {31'b0, hazard}, 32'h1);
    tick();
    checkOutput("stall rs2 holds", rs2_data, 32'hA5A5A5A5);
    applyStimulus(1, 9, 32'h55, 1, 0, 9, 0, 0);
    #1 checkOutput("release hazard", {31'b0, hazard}, 32'h0);
    tick();
    checkOutput("release rs2", rs2_data, 32'h55);
    checkOutput("release busy", busy_mask, 32'h0);

    // Simultaneous clear and set
    applyStimulus(1, 4, 32'h44, 0, 0, 0, 1, 4);
    tick();
    checkOutput("clear+set busy", busy_mask, 32'h0000_0010);
    applyStimulus(0, 0, 0, 1, 4, 0, 0, 0);
    #1 checkOutput("clear+set hazard", {31'b0, hazard}, 32'h1);

    // Async reset mid-operation
    applyStimulus(0, 0, 0, 1, 7, 3, 1, 9);
    tick();
    checkOutput("pre-reset busy", busy_mask, 32'h0000_0210);
    checkOutput("pre-reset rs1", rs1_data, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async reset busy", busy_mask, 32'h0);
    checkOutput("async reset rs1", rs1_data, 32'h0);
    checkOutput("async reset rs2", rs2_data, 32'h0);
    reset_n = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    checkOutput("x7 after reset", rs1_data, 32'h0);

    // Randomized traffic; narrow address range to force collisions
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom(),
                    $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)));
      if ($urandom_range(0, 15) == 0) begin
        write_addr = 5'($urandom_range(0, 31));
        rs1_addr   = 5'($urandom_range(0, 31));
      end
      tick();
    end

    @(negedge clock);
    #1 checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
